// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding and access-size codes for the memory arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FETCH = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // The reserved code behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == SZ_BYTE || size == SZ_HALF) ? size : SZ_WORD;
  endfunction

endpackage

// File: rtl/align_check.sv
// rtl/align_check.sv - flags data accesses whose address is not aligned to their size
module align_check
  import arb_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [1:0] size,
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b0;
    case (norm_size(size))
      SZ_HALF: misaligned = addr_lo[0];
      SZ_WORD: misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch and load/store requests onto one single-port memory
module mem_arbiter
  import arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_misalign,
  output logic        stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  state_t state;
  logic   misaligned;
  logic   d_take;
  logic   f_take;

  align_check u_align (
    .addr_lo    (d_addr[1:0]),
    .size       (d_size),
    .misaligned (misaligned)
  );

  // A requester is not re-granted in the cycle its valid pulse is out.
  assign d_take = (d_read | d_write) & ~d_valid;
  assign f_take = if_req & ~if_valid & ~flush;
  assign stall  = d_take | f_take;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      if_rdata   <= '0;
      if_valid   <= 1'b0;
      d_rdata    <= '0;
      d_valid    <= 1'b0;
      d_misalign <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_size   <= '0;
    end else begin
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      d_misalign <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (d_take) begin
            if (misaligned) begin
              d_valid    <= 1'b1;
              d_misalign <= 1'b1;
            end else begin
              mem_en    <= 1'b1;
              mem_we    <= d_write;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_size  <= norm_size(d_size);
              state     <= ST_DATA;
            end
          end else if (f_take) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_size  <= SZ_WORD;
            state     <= ST_FETCH;
          end
        end
        ST_DATA: begin
          if (mem_ready) begin
            mem_en  <= 1'b0;
            d_valid <= 1'b1;
            if (!mem_we) d_rdata <= mem_rdata;
            state   <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          // A redirect landing on the completion cycle discards that result too.
          if (flush) begin
            if (mem_ready) begin
              mem_en <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              state <= ST_DROP;
            end
          end else if (mem_ready) begin
            mem_en   <= 1'b0;
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (mem_ready) begin
            mem_en <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector and sequence bench for mem_arbiter
module tb_mem_arbiter;
  import arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        flush = 1'b0;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [1:0]  d_size = SZ_WORD;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_misalign;
  logic        stall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .flush      (flush),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_size     (d_size),
    .if_rdata   (if_rdata),
    .if_valid   (if_valid),
    .d_rdata    (d_rdata),
    .d_valid    (d_valid),
    .d_misalign (d_misalign),
    .stall      (stall),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_size   (mem_size),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: ready after ready_delay extra mem_en cycles, logs accepted accesses.
  int          ready_delay = 0;
  logic [31:0] rdata_val = '0;
  int          rcnt = 0;
  int          acc_n = 0;
  logic        acc_we[16];
  logic [31:0] acc_addr[16];
  logic [31:0] acc_wdata[16];
  logic [1:0]  acc_size[16];
  int          dv_n = 0;
  int          iv_n = 0;
  int          memen_n = 0;
  int          stable_err = 0;
  logic [66:0] prev_req = '0;
  logic        prev_en = 1'b0;

  always @(negedge clk) begin
    if (d_valid === 1'b1) dv_n++;
    if (if_valid === 1'b1) iv_n++;
    if (mem_en === 1'b1) begin
      memen_n++;
      if (prev_en && prev_req !== {mem_we, mem_size, mem_addr, mem_wdata}) stable_err++;
      prev_req = {mem_we, mem_size, mem_addr, mem_wdata};
      if (rcnt == ready_delay) begin
        mem_ready = 1'b1;
        mem_rdata = rdata_val;
        rcnt = 0;
        if (acc_n < 16) begin
          acc_we[acc_n]    = mem_we;
          acc_addr[acc_n]  = mem_addr;
          acc_wdata[acc_n] = mem_wdata;
          acc_size[acc_n]  = mem_size;
        end
        acc_n++;
      end else begin
        mem_ready = 1'b0;
        rcnt++;
      end
    end else begin
      mem_ready = 1'b0;
      rcnt = 0;
    end
    prev_en = (mem_en === 1'b1);
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    int          delay;
    logic [31:0] rdata;
    int          exp_lat;
    logic        exp_mis;
    logic        exp_we;
    logic [1:0]  exp_size;
    logic [31:0] exp_drdata;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v, input int idx);
    int   lat;
    int   base_acc;
    int   base_en;
    int   base_dv;
    logic got;
    logic stall_ok;
    logic mis_at;
    logic [31:0] rd_at;
    logic stall_at;
    base_acc = acc_n;
    base_en = memen_n;
    base_dv = dv_n;
    ready_delay = v.delay;
    rdata_val = v.rdata;
    @(negedge clk);
    d_read = v.rd;
    d_write = v.wr;
    d_addr = v.addr;
    d_wdata = v.wdata;
    d_size = v.size;
    lat = 0;
    got = 1'b0;
    stall_ok = 1'b1;
    #1 if (stall !== 1'b1) stall_ok = 1'b0;
    while (!got && lat < 30) begin
      @(negedge clk);
      lat++;
      if (d_valid === 1'b1) got = 1'b1;
      else if (stall !== 1'b1) stall_ok = 1'b0;
    end
    mis_at = d_misalign;
    rd_at = d_rdata;
    stall_at = stall;
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d_misalign", idx), {31'b0, mis_at}, {31'b0, v.exp_mis});
    check($sformatf("v%0d_d_rdata", idx), rd_at, v.exp_drdata);
    check($sformatf("v%0d_stall_before", idx), {31'b0, stall_ok}, 32'd1);
    check($sformatf("v%0d_stall_at_valid", idx), {31'b0, stall_at}, 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_valid_one_cycle", idx), {31'b0, d_valid}, 32'd0);
    d_read = 1'b0;
    d_write = 1'b0;
    repeat (2) @(negedge clk);
    check($sformatf("v%0d_access_count", idx), acc_n - base_acc, v.exp_mis ? 0 : 1);
    check($sformatf("v%0d_memen_cycles", idx), memen_n - base_en, v.exp_mis ? 0 : v.delay + 1);
    check($sformatf("v%0d_valid_count", idx), dv_n - base_dv, 1);
    if (!v.exp_mis && acc_n > base_acc) begin
      check($sformatf("v%0d_mem_we", idx), {31'b0, acc_we[base_acc]}, {31'b0, v.exp_we});
      check($sformatf("v%0d_mem_addr", idx), acc_addr[base_acc], v.addr);
      check($sformatf("v%0d_mem_size", idx), {30'b0, acc_size[base_acc]}, {30'b0, v.exp_size});
      if (v.exp_we) check($sformatf("v%0d_mem_wdata", idx), acc_wdata[base_acc], v.wdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int dv0;
    int iv0;
    int cyc;
    int dcyc;
    int icyc;
    int n;
    int en_seen;
    logic got;

    //                rd    wr    addr          wdata         size     dly rdata         lat mis   we    size     d_rdata
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        SZ_WORD, 0, 32'hDEAD_BEEF, 2, 1'b0, 1'b0, SZ_WORD, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0203, 32'h55,       SZ_BYTE, 1, 32'h1111_1111, 3, 1'b0, 1'b1, SZ_BYTE, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0102, 32'h0,        SZ_HALF, 2, 32'h0000_1234, 4, 1'b0, 1'b0, SZ_HALF, 32'h0000_1234};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0101, 32'h0,        SZ_HALF, 0, 32'h0000_0099, 1, 1'b1, 1'b0, SZ_HALF, 32'h0000_1234};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0102, 32'h0,        SZ_WORD, 0, 32'h0000_0099, 1, 1'b1, 1'b0, SZ_WORD, 32'h0000_1234};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0300, 32'hA5A5A5A5, 2'b11,   0, 32'h0,         2, 1'b0, 1'b1, SZ_WORD, 32'h0000_1234};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0301, 32'hA5A5A5A5, 2'b11,   0, 32'h0,         1, 1'b1, 1'b1, SZ_WORD, 32'h0000_1234};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0400, 32'hCAFEF00D, SZ_WORD, 0, 32'h7777_7777, 2, 1'b0, 1'b1, SZ_WORD, 32'h0000_1234};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_0003, 32'h0,        SZ_BYTE, 1, 32'h0000_00AB, 3, 1'b0, 1'b0, SZ_BYTE, 32'h0000_00AB};
    vecs[9] = '{1'b1, 1'b0, 32'h0000_0800, 32'h0,        SZ_WORD, 0, 32'h0000_0031, 2, 1'b0, 1'b0, SZ_WORD, 32'h0000_0031};

    repeat (3) @(negedge clk);
    check("reset_mem_en", {31'b0, mem_en}, 32'd0);
    check("reset_valids", {29'b0, if_valid, d_valid, d_misalign}, 32'd0);
    check("reset_d_rdata", d_rdata, 32'd0);
    check("reset_if_rdata", if_rdata, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_stall", {31'b0, stall}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Store and fetch arrive together; store goes first, fetch follows.
    base = acc_n;
    dv0 = dv_n;
    iv0 = iv_n;
    ready_delay = 3;
    rdata_val = 32'h0010_0093;
    @(negedge clk);
    d_write = 1'b1;
    d_addr = 32'h0000_0600;
    d_wdata = 32'h1234_5678;
    d_size = SZ_WORD;
    if_req = 1'b1;
    if_addr = 32'h0000_0500;
    cyc = 0;
    dcyc = -1;
    icyc = -1;
    while ((dcyc < 0 || icyc < 0) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (dcyc >= 0) d_write = 1'b0;
      if (icyc >= 0) if_req = 1'b0;
      if (d_valid === 1'b1 && dcyc < 0) dcyc = cyc;
      if (if_valid === 1'b1 && icyc < 0) icyc = cyc;
    end
    @(negedge clk);
    d_write = 1'b0;
    if_req = 1'b0;
    repeat (3) @(negedge clk);
    check("race_store_cycle", dcyc, 5);
    check("race_fetch_cycle", icyc, 10);
    check("race_access_count", acc_n - base, 2);
    check("race_first_we", {31'b0, acc_we[base]}, 32'd1);
    check("race_first_addr", acc_addr[base], 32'h0000_0600);
    check("race_second_we", {31'b0, acc_we[base + 1]}, 32'd0);
    check("race_second_addr", acc_addr[base + 1], 32'h0000_0500);
    check("race_d_valid_count", dv_n - dv0, 1);
    check("race_if_valid_count", iv_n - iv0, 1);
    check("race_if_rdata", if_rdata, 32'h0010_0093);

    // Flush in IDLE blocks the grant; flush in FETCH drops the result.
    base = acc_n;
    iv0 = iv_n;
    ready_delay = 2;
    rdata_val = 32'hBAD0_BAD0;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h0000_0040;
    flush = 1'b1;
    #1 check("flush_stall_low", {31'b0, stall}, 32'd0);
    @(negedge clk);
    check("flush_idle_no_grant", {31'b0, mem_en}, 32'd0);
    flush = 1'b0;
    #1 check("fetch_stall_high", {31'b0, stall}, 32'd1);
    @(negedge clk);
    check("fetch40_mem_en", {31'b0, mem_en}, 32'd1);
    check("fetch40_mem_addr", mem_addr, 32'h0000_0040);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    if_addr = 32'h0000_0080;
    @(negedge clk);
    @(negedge clk);
    check("drop_no_if_valid", {31'b0, if_valid}, 32'd0);
    check("drop_if_rdata_kept", if_rdata, 32'h0010_0093);
    check("drop_mem_en_low", {31'b0, mem_en}, 32'd0);
    rdata_val = 32'h0000_0513;
    @(negedge clk);
    check("fetch80_mem_en", {31'b0, mem_en}, 32'd1);
    check("fetch80_mem_addr", mem_addr, 32'h0000_0080);
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (if_valid === 1'b1) got = 1'b1;
    end
    check("fetch80_done", {31'b0, got}, 32'd1);
    check("fetch80_if_rdata", if_rdata, 32'h0000_0513);
    @(negedge clk);
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    check("flush_if_valid_count", iv_n - iv0, 1);
    check("flush_access_count", acc_n - base, 2);
    check("flush_first_addr", acc_addr[base], 32'h0000_0040);

    // Reset while a load is waiting on memory.
    dv0 = dv_n;
    ready_delay = 5;
    rdata_val = 32'h5A5A_5A5A;
    @(negedge clk);
    d_read = 1'b1;
    d_addr = 32'h0000_0700;
    d_size = SZ_WORD;
    @(negedge clk);
    check("rst_pre_mem_en", {31'b0, mem_en}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_mem_en", {31'b0, mem_en}, 32'd0);
    check("rst_mid_flags", {27'b0, if_valid, d_valid, d_misalign, mem_we, mem_en}, 32'd0);
    check("rst_mid_d_rdata", d_rdata, 32'd0);
    check("rst_mid_if_rdata", if_rdata, 32'd0);
    check("rst_mid_mem_addr", mem_addr, 32'd0);
    check("rst_mid_mem_wdata", mem_wdata, 32'd0);
    check("rst_mid_mem_size", {30'b0, mem_size}, 32'd0);
    rst = 1'b1;
    d_read = 1'b0;
    en_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_en !== 1'b0) en_seen++;
    end
    check("rst_no_mem_en_after", en_seen, 0);
    check("rst_no_d_valid", dv_n - dv0, 0);

    run_vec(vecs[9], 9);

    check("mem_request_stable", stable_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
